qfix_divider: RTL and testbench
===============================

Name: qfix_divider

Overview:
- Parametrised iterative signed fixed-point divider; next generation of the team's fixed Q-format divider.
- Format width, fractional bits, radix and rounding are configurable.
- Adds a launch/valid handshake, sign-correct infinity results, overflow saturation and status flags.
- Sits beside the fixed-point multiplier in the arithmetic unit and is shared by the shader/intersection datapath.

Parameters:
- WIDTH, 64, total word width (two's complement).
- FRAC, 16, fractional bits; 0 < FRAC < WIDTH.
- BPC, 1, quotient bits resolved per cycle (1, 2 or 4); (WIDTH+FRAC) % BPC == 0.
- ROUND, 0, 0 = truncate toward zero; 1 = round half away from zero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- launch  in  1  start request; sampled only when busy=0
- a  in  WIDTH  signed dividend
- b  in  WIDTH  signed divisor
- busy  out  1  operation in progress
- valid  out  1  one-cycle pulse: res and flags updated this cycle
- res  out  WIDTH  quotient; held until the next completion
- nan  out  1  res is NaN
- div_by_zero  out  1  b was zero
- overflow  out  1  finite quotient saturated to infinity

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Encodings:
  - NaN = 1 followed by zeros (most negative value).
  - +inf = 0 followed by ones.
  - -inf = -(+inf).
  - zero = 0.
- Reset: busy=0, valid=0, res=0, nan=0, div_by_zero=0, overflow=0, FSM=IDLE; any operation in progress is abandoned, with no valid pulse.
- Launch handling:
  - launch with busy=0 captures a and b at that edge.
  - launch while busy=1 is ignored; the current operation is not disturbed.
  - Inputs need not be held after the capture edge.
- FSM states: IDLE, SPECIAL, DIVIDE, FINISH.
- IDLE -> SPECIAL when launch and either operand is special; IDLE -> DIVIDE otherwise.
- SPECIAL: busy=1 for one cycle. Result chosen by first matching rule:
  1. a or b is NaN -> NaN.
  2. b zero -> NaN, div_by_zero=1.
  3. a inf and b inf -> NaN.
  4. a inf -> inf with sign a^b.
  5. b inf -> 0.
  6. a zero -> 0.
  - Then valid pulses and the FSM returns to IDLE.
  - Latency is 2 edges: launch captured at edge 0, valid high after edge 1.
- DIVIDE:
  - Magnitudes |a| and |b| are formed at capture.
  - The dividend is |a| shifted left by FRAC (WIDTH+FRAC bits).
  - Unsigned restoring division resolves BPC quotient bits per cycle, MSB first, for N=(WIDTH+FRAC)/BPC cycles.
  - The remainder is retained.
- FINISH (one cycle):
  - Optional rounding: with ROUND=1, magnitude += 1 if 2*remainder >= |b|.
  - Overflow: if magnitude > 2^(WIDTH-1)-1, res = inf with sign a^b and overflow=1.
  - Otherwise res = sign a^b ? -magnitude : magnitude.
  - A negative result never produces the NaN pattern.
  - valid pulses and the FSM returns to IDLE.
- Normal-path latency: launch at edge 0, valid high after edge N+1. busy=1 from edge 0+ until the valid cycle; busy=0 in the valid cycle.
- Flag timing: flags update together with res on valid and hold until the next valid.
- Back-to-back: launch may be asserted in the valid cycle (busy=0) and is accepted.
- A special-path launch never enters DIVIDE.

Test Plan:
- WIDTH=32, FRAC=16, BPC=1: a=0x00018000 (1.5), b=0x00008000 (0.5) -> res=0x00030000, no flags, valid exactly 49 edges after launch edge; busy high for edges 1..48.
- Same config, a=0xFFFF0000 (-1), b=0x00030000 (3): ROUND=0 -> res=0xFFFFAAAB; ROUND=1 -> res=0xFFFFAAAB (-0x5555, since 0.333.. rounds to 0x5555).
- b=0 with a=0x00010000 -> res=0x80000000, nan=1, div_by_zero=1, valid after 2 edges. a=-inf (0x80000001), b=0x00010000 -> res=0x80000001. a=+inf, b=-1 -> res=0x80000001.
- Overflow: a=0x7F000000, b=0x00000001 -> res=0x7FFFFFFF, overflow=1. Same with b=0xFFFFFFFF -> res=0x80000001.
- Relaunch while busy with different operands mid-DIVIDE -> ignored, original result delivered. Reset asserted at cycle 20 -> no valid, all outputs 0; a new launch one cycle later completes normally.
- BPC=4, WIDTH=64, FRAC=16: random signed operands vs a software model (20 cycles + 1); launch in every valid cycle for 1000 operations, zero idle gaps.

Source files
------------

// File: rtl/qfix_divider.sv
// Iterative signed fixed-point divider (Q-format, WIDTH total / FRAC fractional bits).
// Special operands resolve in one cycle; finite quotients use restoring division, BPC bits per cycle.
module qfix_divider #(
    parameter int WIDTH = 64,
    parameter int FRAC  = 16,
    parameter int BPC   = 1,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             launch,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] res,
    output logic             nan,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int DW = WIDTH + FRAC;
    localparam int N  = DW / BPC;
    localparam int CW = $clog2(N + 1);

    localparam logic [WIDTH-1:0] NAN_V  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] PINF_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NINF_V = NAN_V | WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_SPECIAL, S_DIVIDE, S_FINISH} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] rem_q;
    logic [DW-1:0]    quo_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q;
    logic [WIDTH-1:0] sres_q;
    logic             snan_q;
    logic             sdz_q;
    logic             valid_q;
    logic [WIDTH-1:0] res_q;
    logic             nan_q;
    logic             dz_q;
    logic             ovf_q;

    // Operand classification on the live inputs, used only at the capture edge.
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_special, in_sign;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_nan       = (a == NAN_V);
    assign b_nan       = (b == NAN_V);
    assign a_inf       = (a == PINF_V) || (a == NINF_V);
    assign b_inf       = (b == PINF_V) || (b == NINF_V);
    assign a_zero      = (a == '0);
    assign b_zero      = (b == '0);
    assign any_special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    assign in_sign     = a[WIDTH-1] ^ b[WIDTH-1];
    assign a_mag       = a[WIDTH-1] ? -a : a;
    assign b_mag       = b[WIDTH-1] ? -b : b;

    logic [WIDTH-1:0] s_res;
    logic             s_nan;
    logic             s_dz;

    always_comb begin
        s_res = '0;
        s_nan = 1'b0;
        s_dz  = 1'b0;
        if (a_nan || b_nan) begin
            s_res = NAN_V;
            s_nan = 1'b1;
        end else if (b_zero) begin
            s_res = NAN_V;
            s_nan = 1'b1;
            s_dz  = 1'b1;
        end else if (a_inf && b_inf) begin
            s_res = NAN_V;
            s_nan = 1'b1;
        end else if (a_inf) begin
            s_res = in_sign ? NINF_V : PINF_V;
        end
    end

    // One cycle of restoring division. The remainder stays below the divisor,
    // which is below 2^(WIDTH-1), so its top bit can be shifted out safely.
    logic [WIDTH-1:0] rem_n, trial;
    logic [DW-1:0]    quo_n;

    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {rem_n[WIDTH-2:0], quo_n[DW-1]};
            quo_n = {quo_n[DW-2:0], 1'b0};
            if (trial >= d_q) begin
                rem_n    = trial - d_q;
                quo_n[0] = 1'b1;
            end else begin
                rem_n = trial;
            end
        end
    end

    logic             round_up;
    logic [DW:0]      mag_rnd;
    logic             fin_ovf;
    logic [WIDTH-1:0] fin_res;

    always_comb begin
        round_up = (ROUND != 0) && ({rem_q, 1'b0} >= {1'b0, d_q});
        mag_rnd  = {1'b0, quo_q} + {{DW{1'b0}}, round_up};
        fin_ovf  = |mag_rnd[DW:WIDTH-1];
        if (fin_ovf) begin
            fin_res = sign_q ? NINF_V : PINF_V;
        end else begin
            fin_res = sign_q ? -mag_rnd[WIDTH-1:0] : mag_rnd[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (launch) state_d = any_special ? S_SPECIAL : S_DIVIDE;
            S_SPECIAL: state_d = S_IDLE;
            S_DIVIDE:  if (cnt_q == CW'(N - 1)) state_d = S_FINISH;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sres_q  <= '0;
            snan_q  <= 1'b0;
            sdz_q   <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
            nan_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        sign_q <= in_sign;
                        quo_q  <= {a_mag, {FRAC{1'b0}}};
                        d_q    <= b_mag;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        sres_q <= s_res;
                        snan_q <= s_nan;
                        sdz_q  <= s_dz;
                    end
                end
                S_SPECIAL: begin
                    res_q   <= sres_q;
                    nan_q   <= snan_q;
                    dz_q    <= sdz_q;
                    ovf_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
                S_DIVIDE: begin
                    quo_q <= quo_n;
                    rem_q <= rem_n;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FINISH: begin
                    res_q   <= fin_res;
                    nan_q   <= 1'b0;
                    dz_q    <= 1'b0;
                    ovf_q   <= fin_ovf;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign valid       = valid_q;
    assign res         = res_q;
    assign nan         = nan_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_qfix_divider.sv
// Bench for qfix_divider: two 32-bit units (truncate / round) and one 64-bit radix-16 unit
// checked every cycle against an arithmetic model of the quotient, flags, busy and valid timing.
module tb_qfix_divider;
    localparam int FRAC = 16;
    localparam int N32  = (32 + FRAC) / 1;
    localparam int N64  = (64 + FRAC) / 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        launch32, launch64;
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;

    logic        busy0, valid0, nan0, dz0, ovf0;
    logic        busy1, valid1, nan1, dz1, ovf1;
    logic        busy2, valid2, nan2, dz2, ovf2;
    logic [31:0] res0, res1;
    logic [63:0] res2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per unit: expected {overflow, div_by_zero, nan, res} and the cycle its valid is due.
    logic [66:0] exp_q [3][$];
    int          due_q [3][$];
    logic [66:0] held  [3];
    logic [2:0]  valid_v, busy_v;
    logic [66:0] out_v [3];
    logic        cmp_ev, cmp_eb;

    qfix_divider #(.WIDTH(32), .FRAC(FRAC), .BPC(1), .ROUND(0)) u_d0 (
        .clk(clk), .reset(reset), .launch(launch32), .a(a32), .b(b32),
        .busy(busy0), .valid(valid0), .res(res0), .nan(nan0),
        .div_by_zero(dz0), .overflow(ovf0));

    qfix_divider #(.WIDTH(32), .FRAC(FRAC), .BPC(1), .ROUND(1)) u_d1 (
        .clk(clk), .reset(reset), .launch(launch32), .a(a32), .b(b32),
        .busy(busy1), .valid(valid1), .res(res1), .nan(nan1),
        .div_by_zero(dz1), .overflow(ovf1));

    qfix_divider #(.WIDTH(64), .FRAC(FRAC), .BPC(4), .ROUND(1)) u_d2 (
        .clk(clk), .reset(reset), .launch(launch64), .a(a64), .b(b64),
        .busy(busy2), .valid(valid2), .res(res2), .nan(nan2),
        .div_by_zero(dz2), .overflow(ovf2));

    assign valid_v  = {valid2, valid1, valid0};
    assign busy_v   = {busy2, busy1, busy0};
    assign out_v[0] = {ovf0, dz0, nan0, 32'd0, res0};
    assign out_v[1] = {ovf1, dz1, nan1, 32'd0, res1};
    assign out_v[2] = {ovf2, dz2, nan2, res2};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    function automatic void model(input logic [63:0] av, input logic [63:0] bv, input int w,
                                  input int rnd, output logic [66:0] e, output logic sp);
        logic [127:0] mask, nanp, pinf, ninf, aa, bb, ma, mb, q, r, rs;
        logic sg, ai, bi;
        mask = (128'd1 << w) - 128'd1;
        nanp = 128'd1 << (w - 1);
        pinf = nanp - 128'd1;
        ninf = (~pinf + 128'd1) & mask;
        aa   = {64'd0, av} & mask;
        bb   = {64'd0, bv} & mask;
        sg   = aa[w-1] ^ bb[w-1];
        ai   = (aa == pinf) || (aa == ninf);
        bi   = (bb == pinf) || (bb == ninf);
        sp   = 1'b1;
        e    = '0;
        if (aa == nanp || bb == nanp) begin
            e = {3'b001, nanp[63:0]};
        end else if (bb == 128'd0) begin
            e = {3'b011, nanp[63:0]};
        end else if (ai && bi) begin
            e = {3'b001, nanp[63:0]};
        end else if (ai) begin
            e = {3'b000, sg ? ninf[63:0] : pinf[63:0]};
        end else if (bi || aa == 128'd0) begin
            e = '0;
        end else begin
            sp = 1'b0;
            ma = aa[w-1] ? ((~aa + 128'd1) & mask) : aa;
            mb = bb[w-1] ? ((~bb + 128'd1) & mask) : bb;
            q  = (ma << FRAC) / mb;
            r  = (ma << FRAC) % mb;
            if (rnd != 0 && (r << 1) >= mb) q = q + 128'd1;
            if (q > pinf) begin
                e = {3'b100, sg ? ninf[63:0] : pinf[63:0]};
            end else begin
                rs = sg ? ((~q + 128'd1) & mask) : q;
                e  = {3'b000, rs[63:0]};
            end
        end
    endfunction

    task automatic check(input string nm, input int k, input logic [66:0] got, input logic [66:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s unit=%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cmp_ev = 1'b0;
            cmp_eb = 1'b0;
            if (reset) begin
                exp_q[k].delete();
                due_q[k].delete();
                held[k] = '0;
            end else if (due_q[k].size() > 0) begin
                if (cyc >= due_q[k][0]) begin
                    cmp_ev  = 1'b1;
                    held[k] = exp_q[k].pop_front();
                    void'(due_q[k].pop_front());
                end else begin
                    cmp_eb = 1'b1;
                end
            end
            check("valid", k, {66'd0, valid_v[k]}, {66'd0, cmp_ev});
            check("busy", k, {66'd0, busy_v[k]}, {66'd0, cmp_eb});
            check("result", k, out_v[k], held[k]);
        end
    end

    // ---------------- drivers ----------------
    task automatic push(input int k, input logic [63:0] av, input logic [63:0] bv,
                        input int w, input int rnd, input int n);
        logic [66:0] e;
        logic        sp;
        model(av, bv, w, rnd, e, sp);
        exp_q[k].push_back(e);
        due_q[k].push_back(cyc + 1 + (sp ? 1 : n + 1));
    endtask

    // Called at a falling edge; operands are scrambled after the capture edge.
    task automatic go32(input logic [31:0] av, input logic [31:0] bv);
        a32 = av;
        b32 = bv;
        launch32 = 1'b1;
        push(0, {32'd0, av}, {32'd0, bv}, 32, 0, N32);
        push(1, {32'd0, av}, {32'd0, bv}, 32, 1, N32);
        @(negedge clk);
        launch32 = 1'b0;
        a32 = $urandom;
        b32 = $urandom;
    endtask

    task automatic go64(input logic [63:0] av, input logic [63:0] bv);
        a64 = av;
        b64 = bv;
        launch64 = 1'b1;
        push(2, av, bv, 64, 1, N64);
        @(negedge clk);
        launch64 = 1'b0;
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int k, input int bound);
        int n;
        n = 0;
        while (due_q[k].size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (due_q[k].size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout unit=%0d cyc=%0d got=pending exp=done", k, cyc);
        end
    endtask

    task automatic vec32(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] fl,
                         input logic [31:0] r0, input logic [31:0] r1);
        logic [66:0] e;
        logic        sp;
        model({32'd0, av}, {32'd0, bv}, 32, 0, e, sp);
        check("pin_trunc", -1, e, {fl, 32'd0, r0});
        model({32'd0, av}, {32'd0, bv}, 32, 1, e, sp);
        check("pin_round", -1, e, {fl, 32'd0, r1});
        go32(av, bv);
        wait_done(0, 200);
        wait_done(1, 200);
    endtask

    task automatic vec64(input logic [63:0] av, input logic [63:0] bv, input logic [2:0] fl,
                         input logic [63:0] r);
        logic [66:0] e;
        logic        sp;
        model(av, bv, 64, 1, e, sp);
        check("pin_64", -1, e, {fl, r});
        go64(av, bv);
        wait_done(2, 100);
    endtask

    task automatic rnd64(output logic [63:0] v);
        logic [63:0] x;
        x = {$urandom, $urandom} >> $urandom_range(0, 62);
        if ($urandom_range(0, 1) == 1) x = -x;
        case ($urandom_range(0, 19))
            0: x = 64'd0;
            1: x = 64'h8000_0000_0000_0000;
            2: x = 64'h7FFF_FFFF_FFFF_FFFF;
            3: x = 64'h8000_0000_0000_0001;
            default: ;
        endcase
        v = x;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pushed;
        int idle;
        int guard;
        reset    = 1'b1;
        launch32 = 1'b0;
        launch64 = 1'b0;
        a32 = '0;
        b32 = '0;
        a64 = '0;
        b64 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        vec32(32'h0001_8000, 32'h0000_8000, 3'b000, 32'h0003_0000, 32'h0003_0000);
        vec32(32'hFFFF_0000, 32'h0003_0000, 3'b000, 32'hFFFF_AAAB, 32'hFFFF_AAAB);
        vec32(32'h0002_0000, 32'h0003_0000, 3'b000, 32'h0000_AAAA, 32'h0000_AAAB);
        vec32(32'h0000_0001, 32'h0002_0000, 3'b000, 32'h0000_0000, 32'h0000_0001);
        vec32(32'hFFFF_FFFF, 32'h0002_0000, 3'b000, 32'h0000_0000, 32'hFFFF_FFFF);
        vec32(32'hFFFD_0000, 32'hFFFE_0000, 3'b000, 32'h0001_8000, 32'h0001_8000);
        vec32(32'h0001_0000, 32'h0000_0000, 3'b011, 32'h8000_0000, 32'h8000_0000);
        vec32(32'h8000_0001, 32'h0001_0000, 3'b000, 32'h8000_0001, 32'h8000_0001);
        vec32(32'h7FFF_FFFF, 32'hFFFF_0000, 3'b000, 32'h8000_0001, 32'h8000_0001);
        vec32(32'h8000_0000, 32'h0000_0000, 3'b001, 32'h8000_0000, 32'h8000_0000);
        vec32(32'h7FFF_FFFF, 32'h8000_0001, 3'b001, 32'h8000_0000, 32'h8000_0000);
        vec32(32'h0005_0000, 32'h7FFF_FFFF, 3'b000, 32'h0000_0000, 32'h0000_0000);
        vec32(32'h0000_0000, 32'h0003_0000, 3'b000, 32'h0000_0000, 32'h0000_0000);
        vec32(32'h7F00_0000, 32'h0000_0001, 3'b100, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        vec32(32'h7F00_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0001, 32'h8000_0001);
        vec32(32'h0000_7FFF, 32'h0000_0001, 3'b000, 32'h7FFF_0000, 32'h7FFF_0000);
        vec32(32'h0000_8000, 32'h0000_0001, 3'b100, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        vec32(32'hFFFF_8000, 32'h0000_0001, 3'b100, 32'h8000_0001, 32'h8000_0001);

        // A second launch with other operands while dividing must be ignored.
        go32(32'h0001_8000, 32'h0000_8000);
        repeat (10) @(negedge clk);
        launch32 = 1'b1;
        a32 = 32'h0005_0000;
        b32 = 32'h0001_0000;
        repeat (3) @(negedge clk);
        launch32 = 1'b0;
        wait_done(0, 200);
        wait_done(1, 200);

        // Reset mid-divide abandons the operation; the next launch runs normally.
        go32(32'h0002_0000, 32'h0003_0000);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        go32(32'hFFFF_0000, 32'h0003_0000);
        wait_done(0, 200);
        wait_done(1, 200);

        vec64(64'h0000_0000_0001_8000, 64'h0000_0000_0000_8000, 3'b000, 64'h0000_0000_0003_0000);
        vec64(64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0003_0000, 3'b000, 64'hFFFF_FFFF_FFFF_AAAB);
        vec64(64'h0000_0000_0002_0000, 64'h0000_0000_0003_0000, 3'b000, 64'h0000_0000_0000_AAAB);
        vec64(64'h7F00_0000_0000_0000, 64'h0000_0000_0000_0001, 3'b100, 64'h7FFF_FFFF_FFFF_FFFF);
        vec64(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b011, 64'h8000_0000_0000_0000);

        // Back-to-back random operations: launch held high, new operands every cycle.
        launch64 = 1'b1;
        pushed = 0;
        idle   = 0;
        guard  = 0;
        while (pushed < 1000 && guard < 60000) begin
            rnd64(a64);
            rnd64(b64);
            if (!busy2) begin
                if (pushed > 0 && !valid2) idle++;
                push(2, a64, b64, 64, 1, N64);
                pushed++;
            end
            @(negedge clk);
            guard++;
        end
        launch64 = 1'b0;
        wait_done(2, 100);
        check("ops_issued", 2, 67'(pushed), 67'(1000));
        check("idle_gaps", 2, 67'(idle), 67'd0);

        for (int k = 0; k < 3; k++) begin
            check("drain", k, 67'(due_q[k].size()), 67'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
